// File: rtl/pingpong_mem_ctrl_if.sv
// pingpong_mem_ctrl_if: producer/reader side of the ping-pong buffer.
// master = producer + reader, slave = controller.
interface pingpong_mem_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) ();
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_frame_avail;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_done;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  err;

  modport master (
    output wr_valid, wr_data,
    output rd_req, rd_addr, rd_done,
    input  wr_ready, rd_frame_avail,
    input  rd_data, rd_data_valid, err
  );

  modport slave (
    input  wr_valid, wr_data,
    input  rd_req, rd_addr, rd_done,
    output wr_ready, rd_frame_avail,
    output rd_data, rd_data_valid, err
  );
endinterface

// File: rtl/pingpong_mem_ctrl.sv
// pingpong_mem_ctrl: two-bank ping-pong frame buffer over single-port SRAMs.
// Ports: clk, rst_n (sync, low), bus (slave), bank 1/2 cen_n/wen_n/addr/d/q.
module pingpong_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int FRAME_LEN  = 512,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pingpong_mem_ctrl_if.slave    bus,
  output logic                  cen_n_1,
  output logic                  wen_n_1,
  output logic [ADDR_WIDTH-1:0] addr_1,
  output logic [DATA_WIDTH-1:0] d_1,
  input  logic [DATA_WIDTH-1:0] q_1,
  output logic                  cen_n_2,
  output logic                  wen_n_2,
  output logic [ADDR_WIDTH-1:0] addr_2,
  output logic [DATA_WIDTH-1:0] d_2,
  input  logic [DATA_WIDTH-1:0] q_2
);
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_st_t;

  // One extra bit so FRAME_LEN == 2^ADDR_WIDTH still compares
  localparam logic [ADDR_WIDTH:0] FL =
    (ADDR_WIDTH+1)'(FRAME_LEN);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(FRAME_LEN - 1);

  bank_st_t st_q [2];
  bank_st_t st_d [2];

  logic                  wr_sel_q, wr_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                  err_q, err_d;
  logic [RD_LAT-1:0]     pv_q, pv_d;
  logic [RD_LAT-1:0]     ps_q, ps_d;

  logic wr_rdy, rd_av, rd_ok;
  logic wr_acc, wr_last, rd_acc, rel, bad;
  logic w1, w2, r1, r2;
  logic v_out, s_out;

  assign wr_rdy = (st_q[wr_sel_q] == EMPTY);
  assign rd_av  = (st_q[rd_sel_q] == FULL);
  assign rd_ok  = ({1'b0, bus.rd_addr} < FL);

  // Accepts are gated by rst_n so banks stay idle in reset
  assign wr_acc  = rst_n & bus.wr_valid & wr_rdy;
  assign rd_acc  = rst_n & bus.rd_req & rd_av & rd_ok;
  assign rel     = rst_n & bus.rd_done & rd_av;
  assign wr_last = wr_acc & (wr_cnt_q == LAST);

  assign bad = (bus.rd_req & ~(rd_av & rd_ok))
             | (bus.rd_done & ~rd_av);

  always_comb begin
    st_d     = st_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q | bad;
    if (wr_acc) begin
      wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
    end
    if (wr_last) begin
      st_d[wr_sel_q] = FULL;
      wr_cnt_d       = '0;
      wr_sel_d       = ~wr_sel_q;
    end
    // Writer and reader always own different banks
    if (rel) begin
      st_d[rd_sel_q] = EMPTY;
      rd_sel_d       = ~rd_sel_q;
    end
  end

  always_comb begin
    pv_d    = pv_q;
    ps_d    = ps_q;
    pv_d[0] = rd_acc;
    ps_d[0] = rd_sel_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      ps_d[i] = ps_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q[0]  <= EMPTY;
      st_q[1]  <= EMPTY;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
      pv_q     <= '0;
      ps_q     <= '0;
    end else begin
      st_q     <= st_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
      pv_q     <= pv_d;
      ps_q     <= ps_d;
    end
  end

  assign w1 = wr_acc & ~wr_sel_q;
  assign w2 = wr_acc &  wr_sel_q;
  assign r1 = rd_acc & ~rd_sel_q;
  assign r2 = rd_acc &  rd_sel_q;

  assign cen_n_1 = ~(w1 | r1);
  assign wen_n_1 = ~w1;
  assign addr_1  = w1 ? wr_cnt_q :
                   r1 ? bus.rd_addr : '0;
  assign d_1     = w1 ? bus.wr_data : '0;

  assign cen_n_2 = ~(w2 | r2);
  assign wen_n_2 = ~w2;
  assign addr_2  = w2 ? wr_cnt_q :
                   r2 ? bus.rd_addr : '0;
  assign d_2     = w2 ? bus.wr_data : '0;

  assign v_out = rst_n & pv_q[RD_LAT-1];
  assign s_out = ps_q[RD_LAT-1];

  assign bus.wr_ready       = wr_rdy;
  assign bus.rd_frame_avail = rd_av;
  assign bus.err            = err_q;
  assign bus.rd_data_valid  = v_out;
  assign bus.rd_data        = !v_out ? '0 :
                              (s_out ? q_2 : q_1);
endmodule

// File: tb/tb_pingpong_mem_ctrl.sv
// tb_pingpong_mem_ctrl: random + directed bench, frame-queue model.
// Expected reads go to a scoreboard queue popped by a monitor.
module tb_pingpong_mem_ctrl;
  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int FL  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pingpong_mem_ctrl_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) bus ();

  logic          cen_n_1, wen_n_1, cen_n_2, wen_n_2;
  logic [AW-1:0] addr_1, addr_2;
  logic [DW-1:0] d_1, d_2, q_1, q_2;

  pingpong_mem_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .FRAME_LEN(FL), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cen_n_1(cen_n_1), .wen_n_1(wen_n_1),
    .addr_1(addr_1), .d_1(d_1), .q_1(q_1),
    .cen_n_2(cen_n_2), .wen_n_2(wen_n_2),
    .addr_2(addr_2), .d_2(d_2), .q_2(q_2)
  );

  // SRAM models with LAT-cycle read latency
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem2 [0:(1<<AW)-1];
  logic [DW-1:0] rp1 [LAT];
  logic [DW-1:0] rp2 [LAT];

  always @(posedge clk) begin
    if (!cen_n_1 && !wen_n_1) mem1[addr_1] <= d_1;
    if (!cen_n_2 && !wen_n_2) mem2[addr_2] <= d_2;
    rp1[0] <= (!cen_n_1 && wen_n_1) ? mem1[addr_1] : 32'hDEADBEEF;
    rp2[0] <= (!cen_n_2 && wen_n_2) ? mem2[addr_2] : 32'hDEADBEEF;
    for (int i = 1; i < LAT; i++) begin
      rp1[i] <= rp1[i-1];
      rp2[i] <= rp2[i-1];
    end
  end
  assign q_1 = rp1[LAT-1];
  assign q_2 = rp2[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit known = 0;

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: completed frames in order, plus partial frame
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] done_q[$];
  logic [DW-1:0] part_q[$];
  int            nfr = 0;
  bit            m_wb = 0;
  bit            m_rb = 0;
  bit            m_err = 0;

  exp_t e;
  always @(negedge clk) begin
    if (known) begin
      if (bus.rd_data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", bus.rd_data_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", bus.rd_data, e.d);
          chk("rd_latency", cyc, e.due);
        end
      end else begin
        chk("rd_data_idle", bus.rd_data, 0);
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          chk("missing_valid", bus.rd_data_valid, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit rst, input bit wv,
                      input logic [DW-1:0] wd, input bit rq,
                      input int ra, input bit rd);
    bit wacc, racc, rel, w1, w2, r1, r2;
    int wa;
    @(negedge clk);
    if (known) begin
      chk("wr_ready", bus.wr_ready, nfr < 2);
      chk("rd_frame_avail", bus.rd_frame_avail, nfr > 0);
      chk("err", bus.err, m_err);
    end
    #1;
    rst_n        = rst;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_req   = rq;
    bus.rd_addr  = AW'(ra);
    bus.rd_done  = rd;
    wacc = rst && wv && nfr < 2;
    racc = rst && rq && nfr > 0 && ra < FL;
    rel  = rst && rd && nfr > 0;
    wa   = part_q.size();
    w1 = wacc && !m_wb;
    w2 = wacc && m_wb;
    r1 = racc && !m_rb;
    r2 = racc && m_rb;
    #1;
    chk("cen_n_1", cen_n_1, !(w1 || r1));
    chk("wen_n_1", wen_n_1, !w1);
    chk("addr_1", addr_1, w1 ? wa : r1 ? ra : 0);
    chk("d_1", d_1, w1 ? wd : 0);
    chk("cen_n_2", cen_n_2, !(w2 || r2));
    chk("wen_n_2", wen_n_2, !w2);
    chk("addr_2", addr_2, w2 ? wa : r2 ? ra : 0);
    chk("d_2", d_2, w2 ? wd : 0);
    if (!rst) begin
      done_q.delete();
      part_q.delete();
      exp_q.delete();
      nfr = 0;
      m_wb = 0;
      m_rb = 0;
      m_err = 0;
      known = 1;
    end else begin
      if ((rq && !(nfr > 0 && ra < FL)) || (rd && nfr == 0))
        m_err = 1;
      if (racc) exp_q.push_back('{cyc + LAT, done_q[ra]});
      if (wacc) begin
        part_q.push_back(wd);
        if (part_q.size() == FL) begin
          foreach (part_q[k]) done_q.push_back(part_q[k]);
          part_q.delete();
          nfr++;
          m_wb = ~m_wb;
        end
      end
      if (rel) begin
        repeat (FL) void'(done_q.pop_front());
        nfr--;
        m_rb = ~m_rb;
      end
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_cyc();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.wr_valid = 0;
    bus.wr_data  = 0;
    bus.rd_req   = 0;
    bus.rd_addr  = 0;
    bus.rd_done  = 0;
    rst_cyc();
    rst_cyc();

    // Single frame, reverse-order reads, release
    for (int i = 0; i < 4; i++) step(1, 1, 32'hA0 + i, 0, 0, 0);
    for (int i = 3; i >= 0; i--) step(1, 0, 0, 1, i, 0);
    step(1, 0, 0, 0, 0, 1);
    repeat (3) idle();

    // Continuous 12-word stream with concurrent read/release
    begin
      int nw, rp;
      bit wv, rq, rd, wok;
      nw = 0;
      rp = 0;
      for (int c = 0; c < 60; c++) begin
        if (nw >= 12 && nfr == 0) break;
        wv  = (nw < 12);
        wok = (nfr < 2);
        rq  = (nfr > 0);
        rd  = rq && (rp == FL - 1);
        step(1, wv, 32'hB0 + nw, rq, rp, rd);
        if (wv && wok) nw++;
        if (rq) rp = (rp + 1) % FL;
      end
    end
    repeat (3) idle();

    // Fill both banks, stall, release one
    for (int i = 0; i < 8; i++) step(1, 1, 32'hC0 + i, 0, 0, 0);
    step(1, 1, 32'hC8, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 32'hC8, 0, 0, 0);
    rst_cyc();

    // Protocol errors: no frame, then out-of-range address
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 32'hD0 + i, 0, 0, 0);
    step(1, 0, 0, 1, 4, 0);
    repeat (4) idle();
    rst_cyc();

    // Frame 2 completes while frame 1 is released
    for (int i = 0; i < 7; i++) step(1, 1, 32'hE0 + i, 0, 0, 0);
    step(1, 1, 32'hE7, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, i, i == 3);
    repeat (3) idle();

    // Reset mid-frame with live inputs, then a fresh frame
    step(1, 1, 32'hF0, 0, 0, 0);
    step(1, 1, 32'hF1, 0, 0, 0);
    step(0, 1, 32'hFF, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 32'h10 + i, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, i, i == 3);
    repeat (3) idle();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_cyc();
      end else begin
        step(1, ($urandom % 4) != 0, $urandom,
             ($urandom % 2) != 0, $urandom_range(0, FL),
             ($urandom % 5) == 0);
      end
    end

    repeat (LAT + 3) idle();
    chk("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pingpong_mem_ctrl.md
# pingpong_mem_ctrl

Parametrised, clocked ping-pong buffer controller between a frame producer and a frame consumer in the MFCC pipeline, driving two single-port synchronous SRAM banks. It tracks per-bank occupancy and generates write addresses internally. Bank swapping is handshake-driven: the writer fills one bank while the reader randomly accesses the other. Read data is returned with a validated, latency-matched strobe.

## Interface
Parameters:
- DATA_WIDTH, 32, SRAM word width
- ADDR_WIDTH, 12, SRAM address width
- FRAME_LEN, 512, words per frame; 2 ≤ FRAME_LEN ≤ 2^ADDR_WIDTH
- RD_LAT, 1, SRAM read latency in cycles; 1..4

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_valid  in  1  producer has a word
- wr_data  in  DATA_WIDTH  producer word
- wr_ready  out  1  write bank can accept a word
- rd_frame_avail  out  1  a full frame is readable
- rd_req  in  1  read request
- rd_addr  in  ADDR_WIDTH  word index within the frame
- rd_done  in  1  reader releases the current frame
- rd_data  out  DATA_WIDTH  read data
- rd_data_valid  out  1  rd_data valid this cycle
- err  out  1  sticky protocol-error flag
- cen_n_1, cen_n_2  out  1  bank chip enable, active-low
- wen_n_1, wen_n_2  out  1  bank write enable, active-low (0 = write)
- addr_1, addr_2  out  ADDR_WIDTH  bank address
- d_1, d_2  out  DATA_WIDTH  bank write data
- q_1, q_2  in  DATA_WIDTH  bank read data

## Operation
- Each bank has a state: EMPTY or FULL. There is a write pointer wr_sel, a read pointer rd_sel, and a write counter wr_cnt (0..FRAME_LEN-1).
- wr_ready = (state[wr_sel] == EMPTY).
- Write accept = wr_valid & wr_ready.
  - On accept, bank wr_sel gets cen_n=0, wen_n=0, addr=wr_cnt, d=wr_data.
  - wr_cnt then increments.
  - When the accepted word has wr_cnt == FRAME_LEN-1: state[wr_sel] becomes FULL, wr_cnt becomes 0, and wr_sel toggles.
- rd_frame_avail = (state[rd_sel] == FULL).
- Read accept = rd_req & rd_frame_avail & (rd_addr < FRAME_LEN).
  - On accept, bank rd_sel gets cen_n=0, wen_n=1, addr=rd_addr.
- Release = rd_done & rd_frame_avail.
  - On release, state[rd_sel] becomes EMPTY and rd_sel toggles.
  - rd_req and rd_done in the same cycle: the read is issued, then the bank is released.
- Invariant: the writer only touches EMPTY banks and the reader only touches FULL banks, so the two never target the same bank in one cycle. Bank ports are muxed by role.
- An idle bank drives cen_n=1, wen_n=1, addr=0, d=0.
- err sets, and holds until reset, on any of:
  - rd_req while !rd_frame_avail
  - rd_req with rd_addr ≥ FRAME_LEN
  - rd_done while !rd_frame_avail
  - The offending request is dropped: no SRAM access, no state change.
- Simultaneous frame completion by the writer and release by the reader: both updates apply in that cycle.

## Timing
- Memory control outputs are combinational from the current state and request inputs, so the SRAM command is issued in the same cycle as the accept.
- wr_ready and rd_frame_avail are combinational from registered state only; they do not depend on any input.
- rd_data_valid asserts exactly RD_LAT cycles after a read accept.
  - A RD_LAT-deep shift register carries the accept flag and the bank select.
  - rd_data = q of the recorded bank when valid, otherwise 0.
  - Back-to-back reads give back-to-back valids.
  - Reads in flight complete normally even if the bank was released.
- Throughput: one write and one read per cycle, concurrently.
- Reset (rst_n low at a clock edge):
  - both banks EMPTY; wr_sel = rd_sel = 0; wr_cnt = 0
  - read pipeline cleared; err = 0
  - While rst_n is low, all bank outputs are idle (cen_n=1, wen_n=1) and rd_data_valid = 0, regardless of inputs.
  - A partial frame or queued frame present at reset is discarded.
- First cycle after reset: wr_ready = 1, rd_frame_avail = 0.

## Test plan
Common setup: FRAME_LEN=4, RD_LAT=2, DATA_WIDTH=32.
1. Write 4 words (0xA0..0xA3), then read addresses 3,2,1,0.
   - Bank1 writes go to addr 0..3 with wen_n_1=0.
   - rd_frame_avail rises the cycle after the 4th write.
   - rd_data = 0xA3, 0xA2, 0xA1, 0xA0, with valid 2 cycles after each request.
2. Stream 12 words continuously while the reader reads and releases each frame as it becomes available.
   - Banks alternate 1, 2, 1.
   - Writes and reads overlap in the same cycles on opposite banks.
   - All data matches; err = 0.
3. Fill both banks with 8 words and no reads.
   - wr_ready = 0 after the 8th write; a 9th wr_valid is held off.
   - One rd_done releases bank1, then wr_ready = 1 the next cycle.
4. rd_req with no frame available, then rd_req with rd_addr = 4 on a full bank.
   - No SRAM access, no rd_data_valid; err = 1 and sticky.
5. Writer completes frame 2 in the same cycle that rd_done releases frame 1.
   - Both banks update correctly; wr_sel and rd_sel each toggle.
6. Drive rst_n = 0 after 2 writes, then write 4 words.
   - All outputs are at reset values during reset.
   - The new frame starts at bank1 addr 0; the old partial data is never read.
